// File: rtl/ddr_read_phase_tuner_if.sv
// Control/status bundle between the read-phase calibration sequencer and the
// DDR3 management logic / clocking block / read-test engine.
interface ddr_read_phase_tuner_if;
   logic       start;
   logic       pll_locked;
   logic       phase_step;
   logic       phase_updn;
   logic       test_req;
   logic       test_done;
   logic       test_pass;
   logic       busy;
   logic       cal_done;
   logic       cal_fail;
   logic [7:0] pass_map;
   logic [2:0] cur_phase;

   modport master (
      input  start, pll_locked, test_done, test_pass,
      output phase_step, phase_updn, test_req, busy, cal_done, cal_fail, pass_map, cur_phase
   );

   modport slave (
      output start, pll_locked, test_done, test_pass,
      input  phase_step, phase_updn, test_req, busy, cal_done, cal_fail, pass_map, cur_phase
   );
endinterface

// File: rtl/ddr_read_phase_tuner.sv
// DDR3 read-capture clock phase calibration: sweeps the 8 phases with one read test
// each, picks the centre of the widest circular passing window and steps there.
module ddr_read_phase_tuner #(
   parameter int SETTLE_CYCLES = 64,
   parameter int TEST_TIMEOUT  = 4096
) (
   input logic                    clk,
   input logic                    rst,
   ddr_read_phase_tuner_if.master bus
);

   localparam int ANALYSE_CYCLES = 16;
   localparam int CNT_MAX = (TEST_TIMEOUT > SETTLE_CYCLES) ? TEST_TIMEOUT : SETTLE_CYCLES;
   localparam int CW = $clog2(CNT_MAX + 1);

   typedef enum logic [3:0] {
      S_IDLE, S_TEST, S_STEP, S_SETTLE, S_ANALYSE, S_MOVE, S_MOVE_SETTLE, S_DONE, S_FAIL
   } state_e;

   state_e        state_q, state_d;
   logic [2:0]    cur_phase_q, cur_phase_d;
   logic [7:0]    pass_map_q, pass_map_d;
   logic [2:0]    sweep_q, sweep_d;
   logic [2:0]    centre_q, centre_d;
   logic [CW-1:0] cnt_q, cnt_d;

   logic       busy, step, updn;
   logic [2:0] diff, best_start, best_centre, idx;
   logic [3:0] best_len, run_len;
   logic       run_on;

   always_comb busy = !(state_q inside {S_IDLE, S_DONE, S_FAIL});
   always_comb diff = centre_q - cur_phase_q;

   // Longest circular run of passes; strict '>' keeps the lowest start on ties.
   always_comb begin
      best_start = '0;
      best_len   = '0;
      run_len    = '0;
      run_on     = 1'b0;
      idx        = '0;
      for (int s = 0; s < 8; s++) begin
         run_len = '0;
         run_on  = 1'b1;
         for (int k = 0; k < 8; k++) begin
            idx = 3'(s + k);
            if (run_on && pass_map_q[idx]) run_len = run_len + 4'd1;
            else                           run_on  = 1'b0;
         end
         if (run_len > best_len) begin
            best_len   = run_len;
            best_start = 3'(s);
         end
      end
      best_centre = best_start + 3'((best_len - 4'd1) >> 1);
   end

   always_comb begin
      state_d     = state_q;
      cur_phase_d = cur_phase_q;
      pass_map_d  = pass_map_q;
      sweep_d     = sweep_q;
      centre_d    = centre_q;
      cnt_d       = cnt_q + CW'(1);
      step        = 1'b0;
      updn        = 1'b0;
      case (state_q)
         S_IDLE, S_DONE, S_FAIL: begin
            cnt_d = '0;
            if (bus.start) begin
               if (!bus.pll_locked) begin
                  state_d = S_FAIL;
               end else begin
                  pass_map_d = '0;
                  sweep_d    = '0;
                  state_d    = S_TEST;
               end
            end
         end
         S_TEST: begin
            if (bus.test_done) begin
               pass_map_d[cur_phase_q] = bus.test_pass;
               sweep_d = sweep_q + 3'd1;
               cnt_d   = '0;
               state_d = (sweep_q == 3'd7) ? S_ANALYSE : S_STEP;
            end else if (cnt_q == CW'(TEST_TIMEOUT - 1)) begin
               state_d = S_FAIL;
            end
         end
         S_STEP: begin
            step        = 1'b1;
            updn        = 1'b1;
            cur_phase_d = cur_phase_q + 3'd1;
            cnt_d       = '0;
            state_d     = S_SETTLE;
         end
         S_SETTLE, S_MOVE_SETTLE: begin
            if (cnt_q == CW'(SETTLE_CYCLES - 1)) begin
               cnt_d   = '0;
               state_d = (state_q == S_SETTLE) ? S_TEST : S_MOVE;
            end
         end
         S_ANALYSE: begin
            if (cnt_q == CW'(ANALYSE_CYCLES - 1)) begin
               cnt_d = '0;
               if (pass_map_q == 8'd0) begin
                  state_d = S_FAIL;
               end else begin
                  centre_d = best_centre;
                  state_d  = S_MOVE;
               end
            end
         end
         S_MOVE: begin
            cnt_d = '0;
            if (diff == 3'd0) begin
               state_d = S_DONE;
            end else begin
               // A 4-phase distance goes up; either direction takes four steps.
               step        = 1'b1;
               updn        = (diff <= 3'd4);
               cur_phase_d = updn ? cur_phase_q + 3'd1 : cur_phase_q - 3'd1;
               state_d     = S_MOVE_SETTLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
      // Lock loss aborts; a step already issued this cycle is still tracked.
      if (busy && !bus.pll_locked) begin
         state_d    = S_FAIL;
         pass_map_d = pass_map_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         cur_phase_q <= '0;
         pass_map_q  <= '0;
         sweep_q     <= '0;
         centre_q    <= '0;
         cnt_q       <= '0;
      end else begin
         state_q     <= state_d;
         cur_phase_q <= cur_phase_d;
         pass_map_q  <= pass_map_d;
         sweep_q     <= sweep_d;
         centre_q    <= centre_d;
         cnt_q       <= cnt_d;
      end
   end

   assign bus.phase_step = step;
   assign bus.phase_updn = updn;
   assign bus.test_req   = (state_q == S_TEST);
   assign bus.busy       = busy;
   assign bus.cal_done   = (state_q == S_DONE);
   assign bus.cal_fail   = (state_q == S_FAIL);
   assign bus.pass_map   = pass_map_q;
   assign bus.cur_phase  = cur_phase_q;

endmodule

// File: tb/tb_ddr_read_phase_tuner.sv
// Bench for ddr_read_phase_tuner: a clocking-block/read-test responder plus a
// window-search model drives directed pass patterns and checks every cycle.
module tb_ddr_read_phase_tuner;

   localparam int SETTLE = 64;
   localparam int TMO    = 4096;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   ddr_read_phase_tuner_if bus();

   ddr_read_phase_tuner #(.SETTLE_CYCLES(SETTLE), .TEST_TIMEOUT(TMO)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int         n_cmp = 0, n_bad = 0;
   int         cyc = 0, last_step = 0, lat_cnt = 0;
   int         n_up = 0, n_dn = 0;
   logic [2:0] tb_phase = '0;
   logic [7:0] exp_map = '0;
   logic [7:0] pattern = '0;
   bit         prev_step, prev_req, stepped, resp_en, noise_en;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [31:0] outs();
      return {15'd0, bus.phase_step, bus.phase_updn, bus.test_req, bus.busy,
              bus.cal_done, bus.cal_fail, bus.pass_map, bus.cur_phase};
   endfunction

   // Expected result from the pattern alone: widest window by trying lengths from 8 down.
   task automatic exp_cal(input logic [7:0] pat, input logic [2:0] sp,
                          output bit ok, output int c, output int up, output int dn);
      int best_s, best_len, endp, diff;
      bit all1;
      best_s = 0; best_len = 0;
      for (int len = 8; len >= 1 && best_len == 0; len--)
         for (int s = 0; s < 8 && best_len == 0; s++) begin
            all1 = 1'b1;
            for (int k = 0; k < len; k++) if (!pat[(s + k) % 8]) all1 = 1'b0;
            if (all1) begin best_len = len; best_s = s; end
         end
      ok   = (best_len != 0);
      c    = (best_s + (best_len - 1) / 2) % 8;
      endp = (int'(sp) + 7) % 8;
      diff = (c - endp + 8) % 8;
      up = 7; dn = 0;
      if (ok && diff <= 4) up = 7 + diff;
      else if (ok)         dn = 8 - diff;
   endtask

   // One clock: absorb the cycle about to be clocked, then check and respond at negedge.
   task automatic tick();
      if (rst) begin
         tb_phase = '0; exp_map = '0; prev_step = 0; prev_req = 0; stepped = 0;
      end else begin
         if (bus.phase_step) begin
            chk("step_back_to_back", 32'(prev_step), 0);
            chk("step_outside_busy", 32'(bus.busy), 1);
         end
         if (bus.test_req && !prev_req && stepped)
            chk("settle_gap", 32'((cyc - last_step) > SETTLE), 1);
         if (bus.test_req && bus.test_done && bus.pll_locked) exp_map[tb_phase] = bus.test_pass;
         if (bus.start && !bus.busy && bus.pll_locked) exp_map = '0;
         if (bus.phase_step) begin
            if (bus.phase_updn) begin tb_phase = tb_phase + 3'd1; n_up++; end
            else                begin tb_phase = tb_phase - 3'd1; n_dn++; end
            last_step = cyc;
            stepped   = 1;
         end
         prev_step = bus.phase_step;
         prev_req  = bus.test_req;
      end
      @(negedge clk);
      cyc++;
      if (!rst) begin
         chk("cur_phase", 32'(bus.cur_phase), 32'(tb_phase));
         chk("pass_map", 32'(bus.pass_map), 32'(exp_map));
         chk("flags_exclusive", 32'(bus.cal_done & bus.cal_fail), 0);
      end
      bus.test_done = 1'b0;
      if (bus.test_req) begin
         if (resp_en) begin
            if (lat_cnt >= int'(tb_phase) % 3) begin
               bus.test_done = 1'b1;
               bus.test_pass = pattern[tb_phase];
               lat_cnt = 0;
            end else lat_cnt++;
         end
      end else begin
         lat_cnt = 0;
         if (noise_en && bus.busy && cyc % 7 == 0) begin
            bus.test_done = 1'b1;
            bus.test_pass = 1'b1;
         end
      end
   endtask

   task automatic do_reset();
      bus.start = 1'b0;
      rst = 1'b1;
      tick(); tick();
      chk("reset_outputs", outs(), 0);
      rst = 1'b0;
      tick();
   endtask

   task automatic run_cal(input logic [7:0] pat, input bit noise, input bit poke,
                          input int lc, input int lu, input int ld);
      bit ok; int c, up, dn, up0, dn0, i;
      pattern = pat; noise_en = noise; resp_en = 1;
      exp_cal(pat, tb_phase, ok, c, up, dn);
      if (lc >= 0) chk("model_centre", c, lc);
      if (lu >= 0) chk("model_up_steps", up, lu);
      if (ld >= 0) chk("model_down_steps", dn, ld);
      up0 = n_up; dn0 = n_dn;
      bus.start = 1'b1; tick(); bus.start = 1'b0;
      i = 0;
      while (bus.busy && i < 3000) begin
         bus.start = poke && (i == 50);
         tick();
         i++;
      end
      bus.start = 1'b0;
      chk("cal_finished", 32'(bus.busy), 0);
      chk("cal_done", 32'(bus.cal_done), 32'(ok));
      chk("cal_fail", 32'(bus.cal_fail), 32'(!ok));
      chk("sweep_map", 32'(bus.pass_map), 32'(pat));
      chk("up_steps", n_up - up0, up);
      chk("down_steps", n_dn - dn0, dn);
      if (ok) chk("final_phase", 32'(bus.cur_phase), c);
      noise_en = 0;
   endtask

   initial begin
      int i, n, s0;
      rst = 1'b1;
      bus.start = 1'b0; bus.pll_locked = 1'b1; bus.test_done = 1'b0; bus.test_pass = 1'b0;
      repeat (3) tick();
      chk("reset_outputs", outs(), 0);
      rst = 1'b0;
      tick();

      run_cal(8'b00111000, 1, 0, 4, 7, 3);
      run_cal(8'b00110011, 0, 0, -1, -1, -1);   // sweep starting from phase 4
      do_reset(); run_cal(8'b10000011, 0, 1, 0, 8, 0);
      do_reset(); run_cal(8'b00110011, 0, 0, 0, 8, 0);
      do_reset(); run_cal(8'hFF, 0, 0, 3, 11, 0);

      // start without lock from DONE: straight to FAIL, done flag cleared
      bus.pll_locked = 1'b0; bus.start = 1'b1; tick(); bus.start = 1'b0;
      chk("nolock_fail", 32'(bus.cal_fail), 1);
      chk("nolock_done_cleared", 32'(bus.cal_done), 0);
      chk("nolock_busy", 32'(bus.busy), 0);
      chk("nolock_map_kept", 32'(bus.pass_map), 32'hFF);
      bus.pll_locked = 1'b1;

      do_reset(); run_cal(8'h00, 1, 0, -1, 7, 0);

      // test_done withheld
      do_reset();
      resp_en = 0;
      bus.start = 1'b1; tick(); bus.start = 1'b0;
      n = 0; i = 0;
      while (!bus.cal_fail && i < TMO + 200) begin
         if (bus.test_req) n++;
         tick(); i++;
      end
      chk("timeout_fail", 32'(bus.cal_fail), 1);
      chk("timeout_req_cycles", n, TMO);
      chk("timeout_req_low", 32'(bus.test_req), 0);
      resp_en = 1;

      // lock lost during the settle after stepping to phase 2
      do_reset();
      pattern = 8'hFF;
      bus.start = 1'b1; tick(); bus.start = 1'b0;
      i = 0;
      while (!(tb_phase == 3'd2 && bus.busy && !bus.test_req) && i < 1000) begin tick(); i++; end
      chk("reached_phase2_settle", 32'(bus.cur_phase), 2);
      repeat (10) tick();
      bus.pll_locked = 1'b0;
      tick();
      chk("abort_cal_fail", 32'(bus.cal_fail), 1);
      chk("abort_req_low", 32'(bus.test_req), 0);
      chk("abort_busy", 32'(bus.busy), 0);
      s0 = n_up + n_dn;
      repeat (150) tick();
      chk("abort_no_steps", n_up + n_dn - s0, 0);
      chk("abort_phase_kept", 32'(bus.cur_phase), 2);
      bus.pll_locked = 1'b1;

      // reset in the middle of a sweep
      do_reset();
      bus.start = 1'b1; tick(); bus.start = 1'b0;
      repeat (100) tick();
      chk("busy_mid_sweep", 32'(bus.busy), 1);
      do_reset();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
